// File: rtl/fpa_share_ctrl.sv
// Shares one fixed-latency FP12 four-input adder between N requesters: round-robin issue,
// tag pipe aligned to the adder latency, and a credit-protected in-order response FIFO.
module fpa_share_ctrl #(
    parameter int N         = 4,
    parameter int IDW       = 2,
    parameter int FPA_LAT   = 7,
    parameter int RSP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*12-1:0]   req_a,
    input  logic [N*12-1:0]   req_b,
    input  logic [N*12-1:0]   req_c,
    input  logic [N*12-1:0]   req_d,
    output logic              fpa_pushin,
    output logic [11:0]       fpa_a,
    output logic [11:0]       fpa_b,
    output logic [11:0]       fpa_c,
    output logic [11:0]       fpa_d,
    input  logic              fpa_pushout,
    input  logic [11:0]       fpa_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [11:0]       rsp_z,
    output logic              idle,
    output logic              err
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int TS = FPA_LAT + 2;

    logic [IDW-1:0]          rr_ptr_q;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [TS-1:0]           tag_v_q;
    logic [TS-1:0][IDW-1:0]  tag_id_q;
    logic                    pushin_q;
    logic [11:0]             a_q, b_q, c_q, d_q;
    logic                    err_q;
    logic [IDW-1:0]          mem_id [RSP_DEPTH];
    logic [11:0]             mem_z  [RSP_DEPTH];

    logic                    issue_ok, grant_found, accept, push, pop;
    logic [IDW-1:0]          grant_id, scan_id;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count every op that still needs a FIFO slot, so a push can never find it full
    // without a simultaneous pop.
    assign issue_ok = en && (({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(RSP_DEPTH));

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int k = 0; k < N; k++) begin
            scan_id = IDW'((int'(rr_ptr_q) + k) % N);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    assign accept = issue_ok && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // The last tag stage lines up with the cycle the adder drives pushout for that op.
    assign push = fpa_pushout && tag_v_q[TS-1];
    assign pop  = (count_q != '0) && rsp_ready;

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            pushin_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            err_q      <= 1'b0;
        end else begin
            pushin_q   <= accept;
            tag_v_q    <= {tag_v_q[TS-2:0], accept};
            tag_id_q   <= {tag_id_q[TS-2:0], grant_id};
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (accept) begin
                rr_ptr_q <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
                a_q      <= req_a[int'(grant_id)*12 +: 12];
                b_q      <= req_b[int'(grant_id)*12 +: 12];
                c_q      <= req_c[int'(grant_id)*12 +: 12];
                d_q      <= req_d[int'(grant_id)*12 +: 12];
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (fpa_pushout ^ tag_v_q[TS-1]) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr_q] <= tag_id_q[TS-1];
            mem_z[wr_ptr_q]  <= fpa_z;
        end
    end

    assign fpa_pushin = pushin_q;
    assign fpa_a      = a_q;
    assign fpa_b      = b_q;
    assign fpa_c      = c_q;
    assign fpa_d      = d_q;
    assign rsp_valid  = (count_q != '0);
    assign rsp_id     = mem_id[rd_ptr_q];
    assign rsp_z      = mem_z[rd_ptr_q];
    assign idle       = (inflight_q == '0) && (count_q == '0);
    assign err        = err_q;

endmodule

// File: tb/tb_fpa_share_ctrl.sv
// Bench for fpa_share_ctrl: a stand-in adder pipeline, a queue-based reference model checked
// every cycle, a table of arbitration vectors and directed multi-cycle sequences.
module tb_fpa_share_ctrl;
    localparam int N         = 4;
    localparam int IDW       = 2;
    localparam int FPA_LAT   = 7;
    localparam int RSP_DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*12-1:0]   req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic              fpa_pushin;
    logic [11:0]       fpa_a, fpa_b, fpa_c, fpa_d;
    logic              fpa_pushout;
    logic [11:0]       fpa_z;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [11:0]       rsp_z;
    logic              idle;
    logic              err;
    logic              inj = 1'b0;

    fpa_share_ctrl #(.N(N), .IDW(IDW), .FPA_LAT(FPA_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .fpa_pushin(fpa_pushin), .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_c(fpa_c), .fpa_d(fpa_d),
        .fpa_pushout(fpa_pushout), .fpa_z(fpa_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
        .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in adder: exact for x+x+x+x on normal numbers, an operand-sensitive hash otherwise.
    function automatic logic [11:0] fpa_fn(input logic [11:0] a, b, c, d);
        if (a == b && b == c && c == d && a[10:6] < 5'd29) return a + 12'h080;
        return a + {b[5:0], b[11:6]} + (c ^ 12'h5A5) + d;
    endfunction

    logic [FPA_LAT:0] fp_v;
    logic [11:0]      fp_z [FPA_LAT+1];
    always @(posedge clk) begin
        if (!reset_n) begin
            fp_v <= '0;
        end else begin
            fp_v    <= {fp_v[FPA_LAT-1:0], fpa_pushin};
            fp_z[0] <= fpa_fn(fpa_a, fpa_b, fpa_c, fpa_d);
            for (int k = 1; k <= FPA_LAT; k++) fp_z[k] <= fp_z[k-1];
        end
    end
    assign fpa_pushout = fp_v[FPA_LAT] | inj;
    assign fpa_z       = fp_z[FPA_LAT];

    typedef struct {
        int          id;
        logic [11:0] z;
        int          ready_at;
    } rsp_t;

    typedef struct {
        logic [3:0] valid;
        logic       en;
        logic [3:0] exp_ready;
    } vec_t;

    rsp_t        q[$];
    int          m_rr = 0;
    bit          m_pushin = 0;
    bit          m_err = 0;
    logic [11:0] m_ops [4];
    int          edges = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [N-1:0] last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*12 +: 12] = 12'($urandom);
            req_b[i*12 +: 12] = 12'($urandom);
            req_c[i*12 +: 12] = 12'($urandom);
            req_d[i*12 +: 12] = 12'($urandom);
        end
    endtask

    // One clock: check DUT against the model just before the edge, then advance the model.
    task automatic step();
        logic [N-1:0] er;
        int           g, idx;
        bit           ev, acc, pop;
        rsp_t         e;
        logic [11:0]  oa, ob, oc, od;
        #1;
        er = '0;
        g  = -1;
        if (en && q.size() < RSP_DEPTH) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && ((req_valid >> idx) & 1) != 0) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        last_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("fpa_pushin", 32'(fpa_pushin), 32'(m_pushin));
        if (m_pushin) begin
            chk("fpa_a", 32'(fpa_a), 32'(m_ops[0]));
            chk("fpa_b", 32'(fpa_b), 32'(m_ops[1]));
            chk("fpa_c", 32'(fpa_c), 32'(m_ops[2]));
            chk("fpa_d", 32'(fpa_d), 32'(m_ops[3]));
        end
        ev = (q.size() > 0) && (q[0].ready_at <= edges);
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_z", 32'(rsp_z), 32'(q[0].z));
        end
        chk("idle", 32'(idle), 32'(q.size() == 0));
        chk("err", 32'(err), 32'(m_err));
        acc = (g >= 0);
        pop = ev && rsp_ready;
        if (acc) begin
            oa = req_a[g*12 +: 12];
            ob = req_b[g*12 +: 12];
            oc = req_c[g*12 +: 12];
            od = req_d[g*12 +: 12];
        end
        @(posedge clk);
        edges++;
        if (pop) begin
            $display("rsp id=%0d z=%03h edge=%0d", q[0].id, q[0].z, edges);
            void'(q.pop_front());
        end
        if (acc) begin
            e.id       = g;
            e.z        = fpa_fn(oa, ob, oc, od);
            e.ready_at = edges + FPA_LAT + 2;
            q.push_back(e);
            m_rr  = (g + 1) % N;
            m_ops[0] = oa; m_ops[1] = ob; m_ops[2] = oc; m_ops[3] = od;
        end
        m_pushin = acc;
        if (inj) m_err = 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        reset_n  = 1'b1;
        q.delete();
        m_rr     = 0;
        m_pushin = 0;
        m_err    = 0;
        #1;
        chk("rst_pushin", 32'(fpa_pushin), 32'd0);
        chk("rst_fpa_a", 32'(fpa_a), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
    endtask

    task automatic drain(input string name);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60 && q.size() > 0; k++) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d responses still outstanding, expected 0", name, q.size());
        end
        #1;
        chk({name, "_idle"}, 32'(idle), 32'd1);
        @(negedge clk);
    endtask

    vec_t tbl[10];
    int   cnt, lat, pc;
    logic [IDW-1:0] got_id;
    logic [11:0]    got_z;

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 4'b0001};
        tbl[1] = '{4'b0001, 1'b1, 4'b0001};
        tbl[2] = '{4'b1111, 1'b1, 4'b0010};
        tbl[3] = '{4'b1011, 1'b1, 4'b1000};
        tbl[4] = '{4'b0110, 1'b0, 4'b0000};
        tbl[5] = '{4'b0110, 1'b1, 4'b0010};
        tbl[6] = '{4'b0000, 1'b1, 4'b0000};
        tbl[7] = '{4'b0101, 1'b1, 4'b0100};
        tbl[8] = '{4'b0011, 1'b1, 4'b0001};
        tbl[9] = '{4'b1100, 1'b1, 4'b0100};

        @(negedge clk);
        do_reset();

        // Round-robin arbitration vectors from a fresh reset.
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].valid;
            en        = tbl[i].en;
            rsp_ready = 1'b1;
            rand_ops();
            step();
            chk($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'(tbl[i].exp_ready));
        end
        drain("tbl");

        // Single op: 1.0+1.0+1.0+1.0 from requester 0.
        en = 1'b1;
        req_valid = 4'b0001;
        req_a[11:0] = 12'h3C0; req_b[11:0] = 12'h3C0;
        req_c[11:0] = 12'h3C0; req_d[11:0] = 12'h3C0;
        rsp_ready = 1'b1;
        step();
        chk("single_ready", 32'(last_ready), 32'b0001);
        cnt = edges;
        pc  = fpa_pushin ? 1 : 0;
        lat = -1;
        got_id = '1;
        got_z  = '0;
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (fpa_pushin) pc++;
            if (rsp_valid && lat < 0) begin
                lat = edges - cnt;
                got_id = rsp_id;
                got_z  = rsp_z;
            end
        end
        chk("single_pushin_cycles", 32'(pc), 32'd1);
        chk("single_latency", 32'(lat), 32'd9);
        chk("single_id", 32'(got_id), 32'd0);
        chk("single_z", 32'(got_z), 32'h440);
        drain("single");

        // All requesters valid every cycle.
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rand_ops();
            step();
        end
        drain("allvalid");

        // Credit limit: consumer stalled, one requester streaming.
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            rand_ops();
            step();
            if (last_ready[2]) cnt++;
        end
        chk("credit_accepts", 32'(cnt), 32'd8);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            rand_ops();
            step();
            if (last_ready[2]) cnt++;
        end
        chk("credit_one_more", 32'(cnt), 32'd1);
        // Near-full FIFO with pushes and pops landing together.
        rsp_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            rand_ops();
            step();
        end
        drain("fullpp");

        // en dropped mid-burst.
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            step();
        end
        en = 1'b0;
        step();
        chk("en_off_ready", 32'(last_ready), 32'd0);
        for (int k = 0; k < 3; k++) step();
        en = 1'b1;
        drain("en_off");

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            step();
        end
        en = 1'b1;
        drain("random");

        // Reset with three ops in flight.
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step();
        end
        do_reset();
        req_valid = '0;
        for (int k = 0; k < 15; k++) step();
        chk("post_reset_err", 32'(err), 32'd0);

        // Stray pushout with no tag.
        inj = 1'b1;
        step();
        inj = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("stray_err_sticky", 32'(err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
